// File: rtl/bit_deserializer.sv
// bit_deserializer: gathers LANES-bit beats into WIDTH-bit words and
// presents each completed word on a valid/ready holding register.
module bit_deserializer #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter int MSB_FIRST = 0,
  localparam int BEATS    = WIDTH / LANES,
  localparam int CW       = $clog2(BEATS + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [LANES-1:0] i_a,
  input  logic             i_clear,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_a,
  output logic             o_valid,
  output logic [CW-1:0]    o_count,
  output logic             o_overrun
);

  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [31:0]      base;
  logic [WIDTH-1:0] lane_ext;
  logic [WIDTH-1:0] lane_mask;
  logic [WIDTH-1:0] word;
  logic             accept;
  logic             last;

  // merge the current beat into its slice of the partial word
  always_comb begin
    base = 32'(idx_q) * 32'(LANES);
    if (MSB_FIRST != 0) begin
      base = 32'(WIDTH - LANES) - base;
    end
    lane_ext  = WIDTH'(i_a) << base;
    lane_mask = WIDTH'({LANES{1'b1}}) << base;
    word      = (x_q & ~lane_mask) | lane_ext;
  end

  assign accept = i_valid & ~i_clear;
  assign last   = accept & (idx_q == LAST);

  // next-state for collection and the output holding register
  always_comb begin
    x_d     = x_q;
    idx_d   = idx_q;
    a_d     = a_q;
    ovr_d   = ovr_q;
    valid_d = valid_q & ~i_ready;
    if (i_clear) begin
      x_d   = '0;
      idx_d = '0;
    end else if (accept) begin
      if (last) begin
        x_d   = '0;
        idx_d = '0;
      end else begin
        x_d   = word;
        idx_d = idx_q + 1'b1;
      end
    end
    if (last) begin
      if (!valid_q || i_ready) begin
        a_d     = word;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // state registers, cleared asynchronously
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q     <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      x_q     <= x_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_a       = a_q;
  assign o_valid   = valid_q;
  assign o_count   = idx_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_bit_deserializer.sv
// tb_bit_deserializer: three configurations driven in parallel and
// checked every cycle against a beat-list reference model.
module tb_bit_deserializer;

  logic       clk;
  logic       rst;
  logic       vld;
  logic       clr;
  logic       rdy;
  logic [1:0] a_in;

  logic [7:0] oa0, oa1, oa2;
  logic       ov0, ov1, ov2;
  logic [3:0] cnt0, cnt1;
  logic [2:0] cnt2;
  logic       or0, or1, or2;

  int n_cmp = 0;
  int n_err = 0;

  // model state per instance
  int lanes [3] = '{1, 1, 2};
  int msbf  [3] = '{0, 1, 0};
  int m_nb  [3];
  int m_acc [3];
  int m_out [3];
  int m_vld [3];
  int m_ovr [3];

  bit_deserializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_a(a_in[0:0]),
    .i_clear(clr), .i_ready(rdy), .o_a(oa0), .o_valid(ov0),
    .o_count(cnt0), .o_overrun(or0)
  );

  bit_deserializer #(.WIDTH(8), .LANES(1), .MSB_FIRST(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_a(a_in[0:0]),
    .i_clear(clr), .i_ready(rdy), .o_a(oa1), .o_valid(ov1),
    .o_count(cnt1), .o_overrun(or1)
  );

  bit_deserializer #(.WIDTH(8), .LANES(2), .MSB_FIRST(0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_valid(vld), .i_a(a_in),
    .i_clear(clr), .i_ready(rdy), .o_a(oa2), .o_valid(ov2),
    .o_count(cnt2), .o_overrun(or2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_nb[m]  = 0;
      m_acc[m] = 0;
      m_out[m] = 0;
      m_vld[m] = 0;
      m_ovr[m] = 0;
    end
  endtask

  // one clock edge of the behavioural reference
  task automatic model_step();
    for (int m = 0; m < 3; m++) begin
      int l, beat, pos, word, nv;
      bit done;
      l    = lanes[m];
      done = 1'b0;
      word = 0;
      if (clr) begin
        m_nb[m]  = 0;
        m_acc[m] = 0;
      end else if (vld) begin
        beat = int'(a_in) % (1 << l);
        pos  = msbf[m] ? (8 - l - m_nb[m] * l) : (m_nb[m] * l);
        m_acc[m] += beat * (1 << pos);
        m_nb[m]++;
        if (m_nb[m] == 8 / l) begin
          done     = 1'b1;
          word     = m_acc[m];
          m_nb[m]  = 0;
          m_acc[m] = 0;
        end
      end
      nv = (m_vld[m] != 0 && !rdy) ? 1 : 0;
      if (done) begin
        if (m_vld[m] == 0 || rdy) begin
          m_out[m] = word;
          nv       = 1;
        end else begin
          m_ovr[m] = 1;
        end
      end
      m_vld[m] = nv;
    end
  endtask

  task automatic check_all();
    chk("u0_a",   int'(oa0),  m_out[0]);
    chk("u0_vld", int'(ov0),  m_vld[0]);
    chk("u0_cnt", int'(cnt0), m_nb[0]);
    chk("u0_ovr", int'(or0),  m_ovr[0]);
    chk("u1_a",   int'(oa1),  m_out[1]);
    chk("u1_vld", int'(ov1),  m_vld[1]);
    chk("u1_cnt", int'(cnt1), m_nb[1]);
    chk("u1_ovr", int'(or1),  m_ovr[1]);
    chk("u2_a",   int'(oa2),  m_out[2]);
    chk("u2_vld", int'(ov2),  m_vld[2]);
    chk("u2_cnt", int'(cnt2), m_nb[2]);
    chk("u2_ovr", int'(or2),  m_ovr[2]);
  endtask

  task automatic cyc(input bit v, input bit c, input bit r,
                     input logic [1:0] a);
    vld  = v;
    clr  = c;
    rdy  = r;
    a_in = a;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send_byte(input logic [7:0] b, input bit r);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] t;
      t = b >> i;
      cyc(1'b1, 1'b0, r, {1'b0, t[0]});
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic [1:0] pairs [4];
    rst  = 1'b1;
    vld  = 1'b0;
    clr  = 1'b0;
    rdy  = 1'b0;
    a_in = '0;
    model_reset();
    #12;
    check_all();
    chk("rst_a", int'(oa0), 0);
    rst = 1'b0;
    #9;

    // 1,0,1,1,0,0,1,0 with ready high
    pat = 8'h4D;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b1, {1'b0, pat[i]});
      if (i < 7) chk("cnt_run", int'(cnt0), i + 1);
    end
    chk("lsb_4D", int'(oa0), 8'h4D);
    chk("msb_B2", int'(oa1), 8'hB2);
    chk("vld_hi", int'(ov0), 1);
    chk("cnt_wrap", int'(cnt0), 0);
    cyc(1'b0, 1'b0, 1'b1, 2'b00);
    chk("vld_one", int'(ov0), 0);

    // two-lane beats with idle gaps
    pairs = '{2'b01, 2'b11, 2'b00, 2'b10};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b1, pairs[i]);
      if (i < 3) begin
        cyc(1'b0, 1'b0, 1'b1, 2'b11);
        cyc(1'b0, 1'b0, 1'b1, 2'b10);
      end
    end
    chk("l2_8D", int'(oa2), 8'h8D);
    cyc(1'b0, 1'b1, 1'b1, 2'b00);

    // overrun with consumer stalled
    send_byte(8'h4D, 1'b0);
    chk("ovr_first", int'(oa0), 8'h4D);
    send_byte(8'hFF, 1'b0);
    chk("ovr_keep", int'(oa0), 8'h4D);
    chk("ovr_set", int'(or0), 1);
    cyc(1'b0, 1'b0, 1'b1, 2'b00);
    chk("ovr_drain", int'(ov0), 0);
    chk("ovr_stick", int'(or0), 1);

    // clear beats a pending beat in the same cycle
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 2'b01);
    cyc(1'b1, 1'b1, 1'b1, 2'b01);
    chk("clr_cnt", int'(cnt0), 0);
    send_byte(8'hA5, 1'b1);
    chk("clr_A5", int'(oa0), 8'hA5);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 3) != 0),
          ($urandom_range(0, 15) == 0),
          ($urandom_range(0, 2) != 0),
          2'($urandom));
    end

    // async reset mid-word with output pending
    send_byte(8'h5A, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 2'b01);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("arst_vld", int'(ov0), 0);
    chk("arst_cnt", int'(cnt0), 0);
    #2;
    rst = 1'b0;
    send_byte(8'h3C, 1'b1);
    chk("post_3C", int'(oa0), 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
